// File: rtl/ps2_kbd_event_rx_if.sv
// PS/2 keyboard event receiver bus: raw PS/2 lines in, decoded key events
// and error status out. The receiver takes the master side; the consumer
// that drives the lines and pops events takes the slave side.
interface ps2_kbd_event_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       event_ready;
  logic       clear_errors;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_release;
  logic       event_extended;
  logic       overflow;
  logic       frame_err;
  logic [7:0] err_count;

  modport master (
    input  ps2_clk, ps2_data, event_ready, clear_errors,
    output event_valid, event_code, event_release, event_extended,
           overflow, frame_err, err_count
  );

  modport slave (
    output ps2_clk, ps2_data, event_ready, clear_errors,
    input  event_valid, event_code, event_release, event_extended,
           overflow, frame_err, err_count
  );
endinterface

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: synchronises the device lines, assembles and
// validates 11-bit frames, decodes E0/F0 prefixes into key events, optionally
// suppresses typematic repeats and buffers events in a FIFO.
module ps2_kbd_event_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FILTER_REPEAT  = 1
) (
  input logic               clock,
  input logic               reset,
  ps2_kbd_event_rx_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kev_t;

  // ---------------- sampler ----------------
  logic [2:0] sync_clk_q, sync_data_q;
  logic       fall, din;

  // Three-flop synchronisers; idle-high so reset never fakes an edge
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_clk_q  <= 3'b111;
      sync_data_q <= 3'b111;
    end else begin
      sync_clk_q  <= {sync_clk_q[1:0], bus.ps2_clk};
      sync_data_q <= {sync_data_q[1:0], bus.ps2_data};
    end
  end

  assign fall = sync_clk_q[2] & ~sync_clk_q[1];
  assign din  = sync_data_q[1];

  // ---------------- frame assembly ----------------
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;      // start, D0..D7, parity
  logic [TW-1:0] to_cnt_q;
  logic          byte_vld_q, frame_err_q;
  logic [7:0]    byte_q;
  logic          frame_ok;

  // start low, stop (current bit) high, odd parity over D0..D7,P
  assign frame_ok = ~shift_q[0] & din & (^shift_q[9:1]);

  // Shift in bits on falling edges, check on bit 10, abandon stalled frames
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      byte_q      <= '0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall) begin
        to_cnt_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q   <= '0;
          byte_vld_q  <= frame_ok;
          frame_err_q <= ~frame_ok;
          byte_q      <= shift_q[8:1];
        end else begin
          shift_q[bit_cnt_q] <= din;
          bit_cnt_q          <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TW'(1);
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  // ---------------- prefix decoder ----------------
  state_t state_q, state_d;
  logic   emit;
  kev_t   ev;

  // Decoder state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Prefix bytes move between states; any other byte ends the sequence
  always_comb begin
    state_d = state_q;
    if (frame_err_q) begin
      state_d = IDLE;
    end else if (byte_vld_q) begin
      case (state_q)
        IDLE:    state_d = (byte_q == 8'hE0) ? EXT :
                           (byte_q == 8'hF0) ? BRK : IDLE;
        EXT:     state_d = (byte_q == 8'hF0) ? EXT_BRK :
                           (byte_q == 8'hE0) ? EXT : IDLE;
        BRK:     state_d = (byte_q == 8'hF0) ? BRK :
                           (byte_q == 8'hE0) ? EXT_BRK : IDLE;
        default: state_d = (byte_q == 8'hF0 || byte_q == 8'hE0) ? EXT_BRK : IDLE;
      endcase
    end
  end

  // Non-prefix byte emits an event flavoured by the accumulated prefixes
  always_comb begin
    emit = 1'b0;
    ev   = '0;
    if (byte_vld_q && byte_q != 8'hE0 && byte_q != 8'hF0) begin
      emit    = 1'b1;
      ev.code = byte_q;
      ev.ext  = (state_q == EXT) || (state_q == EXT_BRK);
      ev.rel  = (state_q == BRK) || (state_q == EXT_BRK);
    end
  end

  // ---------------- repeat filter ----------------
  logic       held_vld_q, held_ext_q;
  logic [7:0] held_code_q;
  logic       held_match, drop, push;

  assign held_match = held_vld_q && (held_ext_q == ev.ext) && (held_code_q == ev.code);
  assign drop       = (FILTER_REPEAT != 0) && emit && !ev.rel && held_match;
  assign push       = emit && !drop;

  // Track the most recently pressed key; its break releases it
  always_ff @(posedge clock) begin
    if (reset) begin
      held_vld_q  <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= '0;
    end else if ((FILTER_REPEAT != 0) && emit) begin
      if (!ev.rel) begin
        held_vld_q  <= 1'b1;
        held_ext_q  <= ev.ext;
        held_code_q <= ev.code;
      end else if (held_match) begin
        held_vld_q <= 1'b0;
      end
    end
  end

  // ---------------- event FIFO ----------------
  kev_t        mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, pop, wr_en, ovf_set;
  kev_t        head;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && bus.event_ready;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  // Pointer update; extra MSB separates full from empty
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are only visible while non-empty
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= ev;
  end

  assign head = empty ? kev_t'('0) : mem_q[rd_q[AW-1:0]];

  // ---------------- error reporting ----------------
  logic       overflow_q;
  logic [7:0] err_cnt_q;

  // Sticky overflow and saturating error count; a fresh error beats a clear
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (ovf_set)               overflow_q <= 1'b1;
      else if (bus.clear_errors) overflow_q <= 1'b0;

      if (frame_err_q) begin
        if (bus.clear_errors)       err_cnt_q <= 8'd1;
        else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (bus.clear_errors) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign bus.event_valid    = !empty;
  assign bus.event_code     = head.code;
  assign bus.event_release  = head.rel;
  assign bus.event_extended = head.ext;
  assign bus.overflow       = overflow_q;
  assign bus.frame_err      = frame_err_q;
  assign bus.err_count      = err_cnt_q;
endmodule
